// File: rtl/truth_table_scanner_pkg.sv
// Shared types and constants for the truth-table scanner and its settle timer.
package truth_table_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int         N_VEC              = 8;
    localparam logic [7:0] EXP_MASK_SOP_01367 = 8'hCB;
    localparam int         CNT_W              = 4;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that measures how long each stimulus vector is held.
module tt_settle_timer
    import truth_table_scanner_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    assign zero = (value == '0);

    // Load wins over decrement; the counter never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec && !zero) begin
            value <= value - 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Steps x/y/z through all 8 vectors, captures s1/s2 into truth tables and
// compares them against each other and against the expected minterm mask.
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int         SETTLE   = 1,
    parameter logic [7:0] EXP_MASK = EXP_MASK_SOP_01367
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic       s1,
    input  logic       s2,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt_sop,
    output logic [7:0] tt_pos,
    output logic       equal,
    output logic       match_exp,
    output logic [3:0] mismatch_cnt,
    output logic [2:0] first_bad,
    output logic       first_bad_vld
);

    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE - 1);
    localparam logic [2:0]       LAST_IDX = 3'(N_VEC - 1);

    state_t           state;
    state_t           state_next;
    logic [2:0]       idx;
    logic             accept;
    logic             timer_load;
    logic             timer_dec;
    logic             timer_zero;
    logic [CNT_W-1:0] timer_value;
    logic             last_vec;
    logic             bad;
    logic [7:0]       sop_next;
    logic [7:0]       pos_next;

    tt_settle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (RELOAD),
        .dec        (timer_dec),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign last_vec = (idx == LAST_IDX);
    assign bad      = (s1 != s2) || (s1 != EXP_MASK[idx]);

    // Tables as they will look after this sample, so the final compare
    // is ready in the same cycle done rises.
    always_comb begin
        sop_next      = tt_sop;
        pos_next      = tt_pos;
        sop_next[idx] = s1;
        pos_next[idx] = s2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    timer_load = 1'b1;
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    state_next = ST_SAMPLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (last_vec) begin
                    state_next = ST_DONE;
                end else begin
                    timer_load = 1'b1;
                    state_next = ST_SETTLE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            {x, y, z}     <= 3'b000;
            tt_sop        <= '0;
            tt_pos        <= '0;
            equal         <= 1'b0;
            match_exp     <= 1'b0;
            mismatch_cnt  <= '0;
            first_bad     <= '0;
            first_bad_vld <= 1'b0;
        end else if (accept) begin
            idx           <= '0;
            {x, y, z}     <= 3'b000;
            tt_sop        <= '0;
            tt_pos        <= '0;
            equal         <= 1'b0;
            match_exp     <= 1'b0;
            mismatch_cnt  <= '0;
            first_bad     <= '0;
            first_bad_vld <= 1'b0;
        end else if (state == ST_SAMPLE) begin
            tt_sop <= sop_next;
            tt_pos <= pos_next;
            if (bad) begin
                mismatch_cnt <= mismatch_cnt + 4'd1;
                if (!first_bad_vld) begin
                    first_bad     <= idx;
                    first_bad_vld <= 1'b1;
                end
            end
            if (last_vec) begin
                equal     <= (sop_next == pos_next);
                match_exp <= (sop_next == EXP_MASK) && (pos_next == EXP_MASK);
            end else begin
                idx       <= idx + 3'd1;
                {x, y, z} <= idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench: random truth tables stand in for the SoP/PoS circuits.
module tb_truth_table_scanner;
    import truth_table_scanner_pkg::*;

    typedef struct {
        logic [7:0] sop;
        logic [7:0] pos;
        logic       equal;
        logic       match;
        logic [3:0] cnt;
        logic [2:0] first;
        logic       vld;
        int         accept_cyc;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] f_sop = 8'hCB;
    logic [7:0] f_pos = 8'hCB;
    logic [7:0] golden;

    logic       x_a, y_a, z_a, s1_a, s2_a, busy_a, done_a, equal_a, match_a, vld_a;
    logic [7:0] tt_sop_a, tt_pos_a;
    logic [3:0] cnt_a;
    logic [2:0] first_a;
    logic       x_b, y_b, z_b, s1_b, s2_b, busy_b, done_b, equal_b, match_b, vld_b;
    logic [7:0] tt_sop_b, tt_pos_b;
    logic [3:0] cnt_b;
    logic [2:0] first_b;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];

    assign s1_a = f_sop[{x_a, y_a, z_a}];
    assign s2_a = f_pos[{x_a, y_a, z_a}];
    assign s1_b = f_sop[{x_b, y_b, z_b}];
    assign s2_b = f_pos[{x_b, y_b, z_b}];

    truth_table_scanner #(.SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .x(x_a), .y(y_a), .z(z_a), .s1(s1_a), .s2(s2_a),
        .busy(busy_a), .done(done_a), .tt_sop(tt_sop_a), .tt_pos(tt_pos_a),
        .equal(equal_a), .match_exp(match_a), .mismatch_cnt(cnt_a),
        .first_bad(first_a), .first_bad_vld(vld_a)
    );

    truth_table_scanner #(.SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .x(x_b), .y(y_b), .z(z_b), .s1(s1_b), .s2(s2_b),
        .busy(busy_b), .done(done_b), .tt_sop(tt_sop_b), .tt_pos(tt_pos_b),
        .equal(equal_b), .match_exp(match_b), .mismatch_cnt(cnt_b),
        .first_bad(first_b), .first_bad_vld(vld_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] minterm_mask();
        int mt[5] = '{0, 1, 3, 6, 7};
        logic [7:0] m = '0;
        foreach (mt[k]) m = m | (8'd1 << mt[k]);
        return m;
    endfunction

    // Reference: a vector is bad if the forms disagree or the SoP misses the mask.
    function automatic exp_t model(input logic [7:0] f1, input logic [7:0] f2, input int acc);
        exp_t e;
        e.sop = f1;
        e.pos = f2;
        e.equal = (f1 == f2);
        e.match = (f1 == golden) && (f2 == golden);
        e.cnt = '0;
        e.first = '0;
        e.vld = 1'b0;
        e.accept_cyc = acc;
        for (int i = 0; i < 8; i++) begin
            if (f1[i] != f2[i] || f1[i] != golden[i]) begin
                e.cnt = e.cnt + 4'd1;
                if (!e.vld) begin
                    e.first = 3'(i);
                    e.vld = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse from the SETTLE=1 scanner consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done_a) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                checkOutput("tt_sop", 32'(tt_sop_a), 32'(e.sop));
                checkOutput("tt_pos", 32'(tt_pos_a), 32'(e.pos));
                checkOutput("equal", 32'(equal_a), 32'(e.equal));
                checkOutput("match_exp", 32'(match_a), 32'(e.match));
                checkOutput("mismatch_cnt", 32'(cnt_a), 32'(e.cnt));
                checkOutput("first_bad", 32'(first_a), 32'(e.first));
                checkOutput("first_bad_vld", 32'(vld_a), 32'(e.vld));
                checkOutput("latency", 32'(cyc - e.accept_cyc + 1), 32'(8 * (1 + 1) + 1));
            end
        end
    end

    task automatic waitDone();
        int n = 0;
        while (!done_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done_a) begin
            failures++;
            $display("[TB] FAIL done_timeout actual=0 required=1");
        end
    endtask

    task automatic applyStimulus(input logic [7:0] f1, input logic [7:0] f2,
                                 input int hold, input bit restart_in_done);
        @(negedge clk);
        f_sop = f1;
        f_pos = f2;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(f1, f2, cyc));
        repeat (hold - 1) @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        waitDone();
        if (restart_in_done) begin
            start_a = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("start_in_done_ignored", 32'(busy_a), 32'd0);
            @(posedge clk);
            #1;
            sb.push_back(model(f1, f2, cyc));
            checkOutput("restart_clears", 32'({tt_sop_a, tt_pos_a, cnt_a, vld_a, busy_a}), 32'd1);
            @(negedge clk);
            start_a = 1'b0;
            waitDone();
        end
        repeat (2) @(negedge clk);
        checkOutput("hold_xyz", 32'({x_a, y_a, z_a}), 32'd7);
        checkOutput("hold_tt_sop", 32'(tt_sop_a), 32'(f1));
        checkOutput("idle_busy", 32'(busy_a), 32'd0);
    endtask

    // SETTLE=3 scanner with start held four cycles: one scan, 4 cycles per vector.
    task automatic settleThreeScan(input logic [7:0] f1, input logic [7:0] f2);
        int   done_cycle = 0;
        int   done_pulses = 0;
        int   seq_bad = 0;
        exp_t e;
        e = model(f1, f2, 0);
        @(negedge clk);
        f_sop = f1;
        f_pos = f2;
        start_b = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 4) start_b = 1'b0;
            if (i <= 32 && seq_bad == 0 && {x_b, y_b, z_b} != 3'((i - 1) / 4)) seq_bad = i;
            if (done_b) begin
                done_pulses++;
                if (done_cycle == 0) begin
                    done_cycle = i;
                    checkOutput("b_tt_sop", 32'(tt_sop_b), 32'(e.sop));
                    checkOutput("b_tt_pos", 32'(tt_pos_b), 32'(e.pos));
                    checkOutput("b_flags", 32'({equal_b, match_b, cnt_b, first_b, vld_b}),
                                32'({e.equal, e.match, e.cnt, e.first, e.vld}));
                end
            end
        end
        checkOutput("b_done_cycle", 32'(done_cycle), 32'd33);
        checkOutput("b_done_pulses", 32'(done_pulses), 32'd1);
        checkOutput("b_vector_seq_bad_cycle", 32'(seq_bad), 32'd0);
        checkOutput("b_busy_after", 32'(busy_b), 32'd0);
    endtask

    task automatic resetMidScan();
        int n = 0;
        @(negedge clk);
        f_sop = golden;
        f_pos = golden;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(golden, golden, cyc));
        @(negedge clk);
        start_a = 1'b0;
        while ({x_a, y_a, z_a} != 3'd4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_idx4", 32'({x_a, y_a, z_a}), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    32'({x_a, y_a, z_a, busy_a, done_a, tt_sop_a, tt_pos_a,
                         equal_a, match_a, cnt_a, first_a, vld_a}), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_reset_idle", 32'({busy_a, done_a, tt_sop_a}), 32'd0);
    endtask

    initial begin
        logic [7:0] r1, r2;
        golden = minterm_mask();
        repeat (3) @(negedge clk);
        checkOutput("reset_state_a",
                    32'({x_a, y_a, z_a, busy_a, done_a, tt_sop_a, tt_pos_a,
                         equal_a, match_a, cnt_a, first_a, vld_a}), 32'd0);
        checkOutput("reset_state_b", 32'({x_b, y_b, z_b, busy_b, done_b, tt_sop_b, vld_b}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(golden, golden, 1, 1'b0);
        applyStimulus(golden, golden | 8'h20, 1, 1'b0);
        applyStimulus(8'h00, golden, 1, 1'b0);
        settleThreeScan(golden, golden);
        settleThreeScan(8'($urandom), 8'($urandom));
        applyStimulus(golden, 8'h4B, 2, 1'b1);
        resetMidScan();
        applyStimulus(golden, golden, 1, 1'b0);

        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 3))
                0: begin r1 = 8'($urandom); r2 = 8'($urandom); end
                1: begin r1 = golden; r2 = golden ^ (8'd1 << $urandom_range(0, 7)); end
                2: begin r1 = 8'($urandom); r2 = r1; end
                default: begin r1 = golden; r2 = golden; end
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(r1, r2, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
